s2p_lanes: RTL and testbench
============================

S2P_LANES -- requirements
Module: s2p_lanes

Interface
REQ-001 Parameter DW, default 8: output word width in bits; legal range 2..64.
REQ-002 Parameter LANES, default 1: serial bits accepted per beat; DW % LANES == 0 is checked at elaboration and is fatal if violated.
REQ-003 Parameter MSB_FIRST, default 1: 1 means the first beat fills the top LANES bits of dout; 0 means the first beat fills the bottom LANES bits.
REQ-004 clk  in  1  sole clock; all logic updates on rising edge.
REQ-005 rstn  in  1  synchronous reset, active-low.
REQ-006 wr_n  in  1  active-low beat strobe; din is sampled only when wr_n=0.
REQ-007 din  in  LANES  serial data beat.
REQ-008 dout_valid  out  1  output word available.
REQ-009 dout_ready  in  1  consumer accepts the word when dout_valid=1.
REQ-010 dout  out  DW  assembled parallel word.
REQ-011 overflow  out  1  one-cycle pulse when a completed word is dropped.
REQ-012 dout_par  out  1  even parity of dout; present only with S2P_PARITY_EN.

Function
REQ-013 BEATS = DW/LANES; a beat counter counts 0..BEATS-1 on each clk with wr_n=0 and wraps to 0 after the last beat.
REQ-014 wr_n=1 holds the counter and shift contents; gaps of any length between beats are legal.
REQ-015 On the clock edge that samples beat BEATS-1, the assembled word (including that beat) loads the output register.
REQ-016 dout_valid asserts in the cycle after the edge that sampled the last beat: latency is 1 clk from the last beat edge.
REQ-017 Output FSM has two states, EMPTY and FULL.
- EMPTY -> FULL on word completion.
- FULL -> EMPTY on dout_valid & dout_ready with no completion in the same cycle.
- FULL -> FULL on handshake plus simultaneous completion; the new word loads and dout_valid stays 1 with no bubble.
REQ-018 dout and dout_valid are stable while dout_valid=1 and dout_ready=0.
REQ-019 Completion while FULL without a handshake in the same cycle drops the new word, keeps the old word, and pulses overflow for exactly 1 clk.
REQ-020 The serial input has no backpressure; the counter never stalls on the output state.
REQ-021 dout contents while dout_valid=0 are don't-care for consumers and hold the last word in RTL.

Reset
REQ-022 rstn=0 at a rising clk edge sets: counter=0, FSM=EMPTY, dout_valid=0, dout=0, overflow=0, and dout_par=0 when present.
REQ-023 Reset mid-word discards the partial word; the first beat after reset release is beat 0.
REQ-024 Reset overrides any simultaneous wr_n=0 or dout_ready=1.

Configuration
REQ-025 Macro S2P_PARITY_EN.
- Defined: dout_par is registered alongside dout, equals ^dout, and obeys the same hold and drop rules.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Structure
REQ-026 Package s2p_pkg holds:
- default parameter constants (S2P_DW_DEF=8, S2P_LANES_DEF=1);
- the output FSM state enum (EMPTY, FULL);
- a function returning the counter width, $clog2(BEATS) with a minimum of 1.
REQ-027 Sub-module s2p_shreg holds the shift register and beat counter and emits word and done; s2p_lanes holds the output FSM, the output register and the overflow logic.

Verification
REQ-028 DW=8, LANES=1, MSB_FIRST=1, dout_ready=1; beats 1,0,1,1,0,0,1,0 on consecutive clks -> dout=8'hB2, dout_valid high for 1 clk, 1 clk after the 8th beat.
REQ-029 Same bits with MSB_FIRST=0 -> dout=8'h4D; with gaps of 3 idle clks between beats -> same dout, latency unchanged from the last beat.
REQ-030 DW=16, LANES=4, MSB_FIRST=1; beats 4'hA, 4'h5, 4'hC, 4'h3 -> dout=16'hA5C3 after 4 beats.
REQ-031 dout_ready=0 held; two full words sent back-to-back -> first word retained, overflow pulses once on the 2nd completion edge, dout_valid stays 1.
REQ-032 dout_ready=1 exactly in the completion cycle of word 2 while word 1 is pending -> word 1 accepted, word 2 loaded, no overflow, dout_valid stays 1.
REQ-033 rstn=0 for 1 clk after 5 of 8 beats, then 8 beats forming 8'h3C -> dout=8'h3C with no residue; with S2P_PARITY_EN, dout_par=0 for 8'h3C and dout_par=1 for 8'h3D.

Source files
------------

// File: rtl/s2p_pkg.sv
// ============================================================================
// Module   : s2p_pkg
// Purpose  : Shared constants, output FSM state type and counter-width helper
//            for the s2p_lanes serial-to-parallel converter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package s2p_pkg;

    localparam int S2P_DW_DEF    = 8;
    localparam int S2P_LANES_DEF = 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } s2p_state_e;

    // Beat counter width; a single-beat word still needs a 1-bit counter.
    function automatic int s2p_cnt_width(input int beats);
        int w;
        w = $clog2(beats);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/s2p_shreg.sv
// ============================================================================
// Module   : s2p_shreg
// Purpose  : Beat counter and shift register; presents the assembled word and
//            a done strobe combinationally in the cycle the last beat arrives.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module s2p_shreg
    import s2p_pkg::*;
#(
    parameter int DW        = S2P_DW_DEF,
    parameter int LANES     = S2P_LANES_DEF,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_n,
    input  logic [LANES-1:0] din_i,
    output logic [DW-1:0]    word_o,
    output logic             done_o
);

    localparam int BEATS = DW / LANES;
    localparam int CW    = s2p_cnt_width(BEATS);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!wr_n) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = !wr_n && (cnt_q == LAST);

    generate
        if (BEATS == 1) begin : g_single
            assign word_o = din_i;
        end else begin : g_shift
            // Holds only the beats already received; the live beat completes the word.
            logic [DW-LANES-1:0] sh_q;
            logic [DW-LANES-1:0] sh_d;

            if (MSB_FIRST != 0) begin : g_msb
                assign word_o = {sh_q, din_i};
                assign sh_d   = word_o[DW-LANES-1:0];
            end else begin : g_lsb
                assign word_o = {din_i, sh_q};
                assign sh_d   = word_o[DW-1:LANES];
            end

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    sh_q <= '0;
                end else if (!wr_n) begin
                    sh_q <= sh_d;
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/s2p_lanes.sv
// ============================================================================
// Module   : s2p_lanes
// Purpose  : Serial-to-parallel converter with valid/ready output register,
//            drop-on-full overflow pulse. Optional S2P_PARITY_EN adds dout_par.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module s2p_lanes
    import s2p_pkg::*;
#(
    parameter int DW        = S2P_DW_DEF,
    parameter int LANES     = S2P_LANES_DEF,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_n,
    input  logic [LANES-1:0] din,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [DW-1:0]    dout,
    output logic             overflow
`ifdef S2P_PARITY_EN
    ,
    output logic             dout_par
`endif
);

    generate
        if ((DW < 2) || (DW > 64) || (LANES < 1) || ((DW % LANES) != 0)) begin : g_bad_cfg
            $fatal(1, "s2p_lanes: illegal DW/LANES combination");
        end
    endgenerate

    logic [DW-1:0] word;
    logic          done;

    s2p_shreg #(
        .DW        (DW),
        .LANES     (LANES),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk    (clk),
        .rstn   (rstn),
        .wr_n   (wr_n),
        .din_i  (din),
        .word_o (word),
        .done_o (done)
    );

    s2p_state_e    state_q;
    s2p_state_e    state_d;
    logic [DW-1:0] dout_q;
    logic [DW-1:0] dout_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          hs;

    assign hs = (state_q == FULL) && dout_ready;

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        ovf_d   = 1'b0;
        if (state_q == EMPTY) begin
            if (done) begin
                state_d = FULL;
                dout_d  = word;
            end
        end else begin
            if (done && hs) begin
                dout_d = word;
            end else if (done) begin
                // Output still owned by the consumer: new word is lost.
                ovf_d = 1'b1;
            end else if (hs) begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= EMPTY;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dout_valid = (state_q == FULL);
    assign dout       = dout_q;
    assign overflow   = ovf_q;

`ifdef S2P_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^dout_d;
        end
    end

    assign dout_par = par_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_s2p_lanes.sv
// ============================================================================
// Module   : tb_s2p_lanes
// Purpose  : Self-checking bench for s2p_lanes over three configurations,
//            compared every cycle against a beat-position reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_s2p_lanes;

    logic       clk = 1'b0;
    logic       rstn;
    logic       wr_n;
    logic       ready;
    logic [0:0] din_a;
    logic [3:0] din_c;

    logic       d_valid [3];
    logic       d_ovf   [3];
    logic [63:0] d_dout [3];
    logic       d_par   [3];

    logic [7:0]  dout_a;
    logic [7:0]  dout_b;
    logic [15:0] dout_c;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    s2p_lanes #(.DW(8), .LANES(1), .MSB_FIRST(1)) u_a (
        .clk(clk), .rstn(rstn), .wr_n(wr_n), .din(din_a),
        .dout_valid(d_valid[0]), .dout_ready(ready), .dout(dout_a), .overflow(d_ovf[0])
`ifdef S2P_PARITY_EN
        , .dout_par(d_par[0])
`endif
    );

    s2p_lanes #(.DW(8), .LANES(1), .MSB_FIRST(0)) u_b (
        .clk(clk), .rstn(rstn), .wr_n(wr_n), .din(din_a),
        .dout_valid(d_valid[1]), .dout_ready(ready), .dout(dout_b), .overflow(d_ovf[1])
`ifdef S2P_PARITY_EN
        , .dout_par(d_par[1])
`endif
    );

    s2p_lanes #(.DW(16), .LANES(4), .MSB_FIRST(1)) u_c (
        .clk(clk), .rstn(rstn), .wr_n(wr_n), .din(din_c),
        .dout_valid(d_valid[2]), .dout_ready(ready), .dout(dout_c), .overflow(d_ovf[2])
`ifdef S2P_PARITY_EN
        , .dout_par(d_par[2])
`endif
    );

`ifndef S2P_PARITY_EN
    assign d_par[0] = 1'b0;
    assign d_par[1] = 1'b0;
    assign d_par[2] = 1'b0;
`endif

    assign d_dout[0] = 64'(dout_a);
    assign d_dout[1] = 64'(dout_b);
    assign d_dout[2] = 64'(dout_c);

    // Reference model: each beat lands at a fixed bit position of the word.
    function automatic int m_dw(input int k);
        return (k == 2) ? 16 : 8;
    endfunction
    function automatic int m_lanes(input int k);
        return (k == 2) ? 4 : 1;
    endfunction
    function automatic bit m_msb(input int k);
        return (k != 1);
    endfunction

    int          m_n     [3];
    logic [63:0] m_acc   [3];
    logic [63:0] m_dout  [3];
    bit          m_valid [3];
    bit          m_ovf   [3];

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_n[k] = 0; m_acc[k] = '0; m_dout[k] = '0; m_valid[k] = 0; m_ovf[k] = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [63:0] v;
            logic [63:0] w;
            bit          done;
            bit          hs;
            int          pos;
            if (!rstn) begin
                m_n[k] = 0; m_acc[k] = '0; m_dout[k] = '0; m_valid[k] = 0; m_ovf[k] = 0;
            end else begin
                hs   = m_valid[k] && ready;
                done = 0;
                w    = '0;
                if (!wr_n) begin
                    v   = (k == 2) ? 64'(din_c) : 64'(din_a);
                    pos = m_msb(k) ? m_dw(k) - m_lanes(k) * (m_n[k] + 1) : m_lanes(k) * m_n[k];
                    m_acc[k] = m_acc[k] | (v << pos);
                    m_n[k]   = m_n[k] + 1;
                    if (m_n[k] == m_dw(k) / m_lanes(k)) begin
                        done = 1; w = m_acc[k]; m_acc[k] = '0; m_n[k] = 0;
                    end
                end
                m_ovf[k] = 0;
                if (done) begin
                    if (!m_valid[k] || hs) begin
                        m_dout[k]  = w;
                        m_valid[k] = 1;
                    end else begin
                        m_ovf[k] = 1;
                    end
                end else if (hs) begin
                    m_valid[k] = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model_valid[%0d]", k), 64'(d_valid[k]), 64'(m_valid[k]));
                chk($sformatf("model_ovf[%0d]", k), 64'(d_ovf[k]), 64'(m_ovf[k]));
                if (m_valid[k]) begin
                    chk($sformatf("model_dout[%0d]", k), d_dout[k], m_dout[k]);
`ifdef S2P_PARITY_EN
                    chk($sformatf("model_par[%0d]", k), 64'(d_par[k]), 64'(^m_dout[k]));
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic b, input logic [3:0] n);
        wr_n  = 1'b0;
        din_a = b;
        din_c = n;
        tick();
        wr_n  = 1'b1;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) beat(w[i], 4'($urandom));
    endtask

    logic [7:0]  pat = 8'hB2;
    logic [15:0] nib = 16'hA5C3;

    initial begin
        rstn = 1'b0; wr_n = 1'b1; ready = 1'b0; din_a = '0; din_c = '0;
        tick(); tick();
        rstn   = 1'b1;
        chk_en = 1'b1;
        chk("reset_valid", 64'(d_valid[0]), 64'd0);
        chk("reset_dout", d_dout[0], 64'd0);
        chk("reset_ovf", 64'(d_ovf[0]), 64'd0);

        // Back-to-back beats, consumer always ready.
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            beat(pat[7-i], nib[15-4*(i%4) -: 4]);
            if (i == 3) chk("lanes4_a5c3", d_dout[2], 64'hA5C3);
        end
        chk("msb_b2", d_dout[0], 64'hB2);
        chk("lsb_4d", d_dout[1], 64'h4D);
        chk("valid_after_last", 64'(d_valid[0]), 64'd1);
        chk("lanes4_word2", d_dout[2], 64'hA5C3);
        tick();
        chk("valid_one_clk", 64'(d_valid[0]), 64'd0);

        // Three idle clocks between beats.
        for (int i = 0; i < 8; i++) begin
            beat(pat[7-i], 4'($urandom));
            if (i != 7) begin
                tick(); tick(); tick();
            end
            if (i == 6) chk("gap_not_yet", 64'(d_valid[0]), 64'd0);
        end
        chk("gap_msb_b2", d_dout[0], 64'hB2);
        chk("gap_lsb_4d", d_dout[1], 64'h4D);
        chk("gap_latency", 64'(d_valid[0]), 64'd1);
        tick();

        // Consumer stalled: second word is dropped.
        ready = 1'b0;
        send_word(8'hB2);
        send_word(8'h3C);
        chk("ovf_pulse", 64'(d_ovf[0]), 64'd1);
        chk("ovf_keep_old", d_dout[0], 64'hB2);
        chk("ovf_valid", 64'(d_valid[0]), 64'd1);
        tick();
        chk("ovf_one_clk", 64'(d_ovf[0]), 64'd0);

        // Handshake in the completion cycle: no bubble, no drop.
        for (int i = 7; i >= 1; i--) beat(pat[i] ^ 1'b0 ? 1'b0 : 1'b0, 4'($urandom));
        ready = 1'b1;
        beat(1'b1, 4'($urandom));
        chk("hs_new_word", d_dout[0], 64'h01);
        chk("hs_valid", 64'(d_valid[0]), 64'd1);
        chk("hs_no_ovf", 64'(d_ovf[0]), 64'd0);
        tick();
        chk("hs_drained", 64'(d_valid[0]), 64'd0);

        // Reset mid-word, overriding a beat and ready.
        for (int i = 0; i < 5; i++) beat(1'b1, 4'($urandom));
        rstn = 1'b0; wr_n = 1'b0; din_a = 1'b1;
        tick();
        rstn = 1'b1; wr_n = 1'b1;
        chk("rst_mid_valid", 64'(d_valid[0]), 64'd0);
        chk("rst_mid_dout", d_dout[0], 64'd0);
        send_word(8'h3C);
        chk("rst_no_residue", d_dout[0], 64'h3C);
`ifdef S2P_PARITY_EN
        chk("par_3c", 64'(d_par[0]), 64'd0);
`endif
        tick();
        send_word(8'h3D);
        chk("after_rst_3d", d_dout[0], 64'h3D);
`ifdef S2P_PARITY_EN
        chk("par_3d", 64'(d_par[0]), 64'd1);
`endif
        tick();

        // Randomized traffic with occasional resets.
        repeat (4000) begin
            rstn  = ($urandom_range(0, 199) != 0);
            wr_n  = ($urandom_range(0, 2) == 0);
            din_a = 1'($urandom);
            din_c = 4'($urandom);
            ready = 1'($urandom);
            tick();
        end
        rstn = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
